// File: rtl/cache_wr_hit_ctrl_if.sv
// CPU write port, snoop bus and memory write-back signals of the write-hit controller.
// The controller uses the slave modport; the CPU/bus/memory side uses the master modport.
interface cache_wr_hit_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          wr;
    logic          cache_hit;
    logic [AW-1:0] addr_write;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          cache_we;
    logic [AW-1:0] cache_waddr;
    logic [DW-1:0] cache_wdata;
    logic          bus_req;
    logic [AW-1:0] inval_addr;
    logic          ack;
    logic          wb_req;
    logic [AW-1:0] wb_addr;
    logic          wb_ack;
    logic          dirty_q;
    logic          busy;

    modport master (
        output wr, cache_hit, addr_write, wr_data, ack, wb_ack,
        input  wr_ready, cache_we, cache_waddr, cache_wdata, bus_req, inval_addr,
               wb_req, wb_addr, dirty_q, busy
    );

    modport slave (
        input  wr, cache_hit, addr_write, wr_data, ack, wb_ack,
        output wr_ready, cache_we, cache_waddr, cache_wdata, bus_req, inval_addr,
               wb_req, wb_addr, dirty_q, busy
    );
endinterface

// File: rtl/cache_wr_hit_ctrl.sv
// Write-hit sequencer: writes the line, marks it dirty, invalidates remote copies,
// and drains dirty lines to memory through a small write-back queue.
module cache_wr_hit_ctrl #(
    parameter int AW        = 10,
    parameter int DW        = 16,
    parameter int WBQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_wr_hit_ctrl_if.slave bus
);
    localparam int PW = $clog2(WBQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        INVAL
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [AW-1:0]        addr_r;
    logic [DW-1:0]        data_r;
    logic [(1<<AW)-1:0]   dirty;
    logic [AW-1:0]        mem [WBQ_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 wb_gap;
    logic                 wb_req;
    logic [AW-1:0]        head;
    logic                 q_full;
    logic                 accept;
    logic                 pop;
    logic                 push;

    assign head   = mem[rd_ptr];
    assign q_full = (count == CW'(WBQ_DEPTH));
    assign wb_req = (count != '0) && !wb_gap;
    assign pop    = wb_req && bus.wb_ack;
    // A line cleaned in the same cycle it is rewritten counts as clean, so it is queued again.
    assign push   = (state == WRITE) && (!dirty[addr_r] || (pop && head == addr_r));

    assign bus.wr_ready    = rst_n && (state == IDLE) && !q_full &&
                             !(wb_req && bus.addr_write == head);
    assign accept          = bus.wr && bus.cache_hit && bus.wr_ready;
    assign bus.cache_we    = (state == WRITE);
    assign bus.cache_waddr = addr_r;
    assign bus.cache_wdata = data_r;
    assign bus.bus_req     = (state == INVAL);
    assign bus.inval_addr  = addr_r;
    assign bus.wb_req      = wb_req;
    assign bus.wb_addr     = wb_req ? head : '0;
    assign bus.dirty_q     = dirty[bus.addr_write];
    assign bus.busy        = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = INVAL;
            INVAL:   if (bus.ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r <= '0;
            data_r <= '0;
        end else if (accept) begin
            addr_r <= bus.addr_write;
            data_r <= bus.wr_data;
        end
    end

    // The dirty set is written after the clear so a rewrite of the head line stays dirty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dirty  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wb_gap <= 1'b0;
        end else begin
            wb_gap <= pop;
            if (pop) begin
                dirty[head] <= 1'b0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            if (state == WRITE) begin
                dirty[addr_r] <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= addr_r;
        end
    end
endmodule
